icache_data_ctrl: RTL and testbench
===================================

Name: icache_data_ctrl

Overview:
- Sequences one way of the instruction-cache data RAM: a single-port array of LINE lines by BLOCK 32-bit words, with byte write enables and 1-cycle read latency.
- Shares the RAM port between the fetch lookup path and the AXI refill engine.
- Assembles wrap-burst refill beats into a line buffer, then writes the whole line in one RAM cycle.
- Sits between the fetch stage, the refill/AXI read channel and the data RAM instance.

Parameters:
- LINE, 128, number of lines (RAM depth); index width IW = clog2(LINE).
- BLOCK, 8, 32-bit words per line (power of two, >=2); offset width OW = clog2(BLOCK).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch read request
- fetch_index  in  IW  line index to read
- fetch_gnt  out  1  request accepted this cycle (RAM read issued)
- fetch_rvalid  out  1  fetch_rdata valid (cycle after gnt)
- fetch_rdata  out  32*BLOCK  line read data (ram_rdata pass-through)
- refill_start  in  1  begin line refill (accepted only when refill_busy=0)
- refill_index  in  IW  line to refill
- refill_off  in  OW  critical word offset; first beat lands here
- beat_valid  in  1  refill beat valid
- beat_data  in  32  refill beat
- beat_last  in  1  AXI RLAST
- beat_ready  out  1  beat accepted when beat_valid && beat_ready
- refill_busy  out  1  state != IDLE
- refill_done  out  1  one-cycle pulse after line write
- refill_err  out  1  sticky beat_last mismatch; cleared by accepted refill_start
- fwd_valid  out  1  critical-word forward strobe (optional feature)
- fwd_data  out  32  critical word (optional feature)
- ram_en  out  1  RAM enable
- ram_wen  out  4*BLOCK  RAM byte write enables
- ram_index  out  IW  RAM address
- ram_wdata  out  32*BLOCK  RAM write line
- ram_rdata  in  32*BLOCK  RAM read line

Behaviour:
- Reset: state=IDLE. All outputs 0 at reset: fetch_gnt, fetch_rvalid, beat_ready, refill_busy, refill_done, refill_err, fwd_valid, fwd_data. Line buffer, ptr and cnt cleared. Mid-operation reset abandons the refill with no RAM write.
- States: IDLE, FILL, WRITE.
- IDLE:
  - fetch_gnt=fetch_req.
  - refill_start -> FILL; latch idx=refill_index, ptr=refill_off, cnt=0, refill_err=0.
  - Simultaneous fetch_req and refill_start: both accepted; the fetch read is issued the same cycle.
- FILL:
  - beat_ready=1. Each accepted beat writes buf[ptr]; ptr=(ptr+1) mod BLOCK, wrapping BLOCK-1 -> 0; cnt++.
  - Fetch is granted unless fetch_index==idx (stale line); a blocked request is not granted and the requester holds it.
  - After the beat with cnt==BLOCK-1 is accepted -> WRITE.
  - beat_last asserted on any other beat, or deasserted on beat BLOCK-1, sets refill_err. The line is still completed by count.
- WRITE:
  - ram_en=1, ram_wen=all ones, ram_index=idx, ram_wdata=buf with word w at bits [32w+31:32w]; fetch_gnt=0; beat_ready=0.
  - Next cycle: refill_done=1 and state=IDLE.
- RAM drive: when fetch_gnt=1, ram_en=1, ram_wen=0, ram_index=fetch_index. When neither a grant nor a write is active, ram_en=0.
- Read data: fetch_rvalid is registered (=fetch_gnt of the previous cycle); fetch_rdata=ram_rdata.
- refill_start outside IDLE is ignored.
- refill_busy is combinational from state.

Optional Feature:
- ICACHE_CRITICAL_FWD_EN defined:
  - On the first accepted beat of a refill (cnt==0), next cycle fwd_valid=1 for exactly one cycle and fwd_data=that beat.
  - fwd_data holds its value until the next forward.
- Not defined: fwd_valid and fwd_data are tied 0 and no forward register exists.

Test Plan:
- After reset, fetch_req=1, fetch_index=5 -> gnt=1, ram_en=1, ram_wen=0, ram_index=5; next cycle fetch_rvalid=1 with fetch_rdata=ram_rdata.
- refill_start with index=9, off=6; 8 beats 0xA0..0xA7 back-to-back with beat_last on the 8th -> WRITE after beat 8: ram_wen=0xFFFFFFFF, ram_index=9, word6=0xA0, word7=0xA1, word0=0xA2 ... word5=0xA7; refill_done pulses 1 cycle later; total 10 cycles from start.
- During FILL of index 9, fetch index 3 -> granted; fetch index 9 -> gnt=0 until state returns to IDLE.
- Beats with 2-cycle gaps plus beat_last on beat 5 -> refill_err=1 and the line is written after beat 8; the next refill_start clears refill_err.
- Assert resetn=0 after 3 beats -> outputs 0 and state IDLE immediately, with no RAM write; a fresh refill then completes normally.
- With ICACHE_CRITICAL_FWD_EN defined and first beat 0xDEADBEEF at off=2 -> fwd_valid=1 for one cycle with fwd_data=0xDEADBEEF; without the macro, fwd_valid stays 0.

Source files
------------

// File: rtl/icache_data_ctrl.sv
// icache_data_ctrl: sequences one way of the I-cache data RAM.
// Shares the single RAM port between fetch lookups and line refills.
// Wrap-burst refill beats are gathered in a line buffer and written in one cycle.
// Optional feature macro: ICACHE_CRITICAL_FWD_EN (critical-word forward).
module icache_data_ctrl #(
    parameter int unsigned LINE  = 128,
    parameter int unsigned BLOCK = 8,
    localparam int unsigned IW   = $clog2(LINE),
    localparam int unsigned OW   = $clog2(BLOCK)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fetch_req,
    input  logic [IW-1:0]         fetch_index,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [32*BLOCK-1:0]   fetch_rdata,
    input  logic                  refill_start,
    input  logic [IW-1:0]         refill_index,
    input  logic [OW-1:0]         refill_off,
    input  logic                  beat_valid,
    input  logic [31:0]           beat_data,
    input  logic                  beat_last,
    output logic                  beat_ready,
    output logic                  refill_busy,
    output logic                  refill_done,
    output logic                  refill_err,
    output logic                  fwd_valid,
    output logic [31:0]           fwd_data,
    output logic                  ram_en,
    output logic [4*BLOCK-1:0]    ram_wen,
    output logic [IW-1:0]         ram_index,
    output logic [32*BLOCK-1:0]   ram_wdata,
    input  logic [32*BLOCK-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_idx;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_cnt;
    logic [31:0]        r_buf [BLOCK];
    logic               r_err;
    logic               r_done;
    logic               r_rvalid;
    logic               w_fetch_gnt;
    logic               w_beat_ready;
    logic               w_beat_acc;
    logic               w_last_beat;
    logic               w_start_acc;
    logic [32*BLOCK-1:0] w_line;

    assign w_beat_acc  = beat_valid && w_beat_ready;
    assign w_last_beat = (r_cnt == OW'(BLOCK - 1));
    assign w_start_acc = (r_state == S_IDLE) && refill_start;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state, fetch arbitration and RAM port drive
    always_comb begin
        w_state_nxt  = r_state;
        w_fetch_gnt  = 1'b0;
        w_beat_ready = 1'b0;
        ram_en       = 1'b0;
        ram_wen      = '0;
        ram_index    = fetch_index;
        case (r_state)
            S_IDLE: begin
                w_fetch_gnt = fetch_req;
                if (refill_start) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                w_beat_ready = 1'b1;
                // the line being refilled is stale until written
                w_fetch_gnt  = fetch_req && (fetch_index != r_idx);
                if (w_beat_acc && w_last_beat) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                ram_en      = 1'b1;
                ram_wen     = '1;
                ram_index   = r_idx;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fetch_gnt) ram_en = 1'b1;
    end

    // Flatten the line buffer into the RAM write bus
    always_comb begin
        w_line = '0;
        for (int i = 0; i < int'(BLOCK); i++) w_line[32*i +: 32] = r_buf[i];
    end

    // Refill bookkeeping: latch target, gather beats, track burst framing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx  <= '0;
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < int'(BLOCK); i++) r_buf[i] <= '0;
        end else if (w_start_acc) begin
            r_idx <= refill_index;
            r_ptr <= refill_off;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_beat_acc) begin
            r_buf[r_ptr] <= beat_data;
            r_ptr        <= r_ptr + 1'b1;
            r_cnt        <= r_cnt + 1'b1;
            if (beat_last != w_last_beat) r_err <= 1'b1;
        end
    end

    // Completion pulse and read-data valid
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_done   <= (r_state == S_WRITE);
            r_rvalid <= w_fetch_gnt;
        end
    end

`ifdef ICACHE_CRITICAL_FWD_EN
    logic        r_fwd_valid;
    logic [31:0] r_fwd_data;

    // Forward the first beat of each refill to the fetch stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_beat_acc && (r_cnt == '0);
            if (w_beat_acc && (r_cnt == '0)) r_fwd_data <= beat_data;
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign fwd_data  = r_fwd_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_data  = '0;
`endif

    assign fetch_gnt    = w_fetch_gnt;
    assign fetch_rvalid = r_rvalid;
    assign fetch_rdata  = ram_rdata;
    assign beat_ready   = w_beat_ready;
    assign refill_busy  = (r_state != S_IDLE);
    assign refill_done  = r_done;
    assign refill_err   = r_err;
    assign ram_wdata    = w_line;

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Directed bench for icache_data_ctrl (LINE=128, BLOCK=8).
// Define ICACHE_CRITICAL_FWD_EN for both files to check the forward path.
module tb_icache_data_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         fetch_req;
    logic [6:0]   fetch_index;
    logic         fetch_gnt;
    logic         fetch_rvalid;
    logic [255:0] fetch_rdata;
    logic         refill_start;
    logic [6:0]   refill_index;
    logic [2:0]   refill_off;
    logic         beat_valid;
    logic [31:0]  beat_data;
    logic         beat_last;
    logic         beat_ready;
    logic         refill_busy;
    logic         refill_done;
    logic         refill_err;
    logic         fwd_valid;
    logic [31:0]  fwd_data;
    logic         ram_en;
    logic [31:0]  ram_wen;
    logic [6:0]   ram_index;
    logic [255:0] ram_wdata;
    logic [255:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_line [8];

    icache_data_ctrl #(.LINE(128), .BLOCK(8)) dut (
        .clk(clk), .resetn(resetn),
        .fetch_req(fetch_req), .fetch_index(fetch_index), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .refill_start(refill_start), .refill_index(refill_index), .refill_off(refill_off),
        .beat_valid(beat_valid), .beat_data(beat_data), .beat_last(beat_last),
        .beat_ready(beat_ready), .refill_busy(refill_busy), .refill_done(refill_done),
        .refill_err(refill_err), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_index(ram_index),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; fetch_req = 1'b0; fetch_index = '0; refill_start = 1'b0;
        refill_index = '0; refill_off = '0; beat_valid = 1'b0; beat_data = '0;
        beat_last = 1'b0; ram_rdata = {8{32'h5A5A_0F0F}};
        step(); step();
        checks++; if ({fetch_gnt, fetch_rvalid, beat_ready, refill_busy} !== 4'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 0000", {fetch_gnt, fetch_rvalid, beat_ready, refill_busy}); end
        checks++; if ({refill_done, refill_err, fwd_valid, ram_en} !== 4'b0) begin
            errors++; $display("FAIL reset_sts got %b exp 0000", {refill_done, refill_err, fwd_valid, ram_en}); end
        checks++; if (fwd_data !== 32'h0) begin
            errors++; $display("FAIL reset_fwd_data got %h exp 0", fwd_data); end
        resetn = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        fetch_req = 1'b1; fetch_index = 7'd5; ram_rdata = {8{32'h1357_9BDF}};
        #1;
        checks++; if ({fetch_gnt, ram_en} !== 2'b11 || ram_wen !== 32'h0 || ram_index !== 7'd5) begin
            errors++; $display("FAIL fetch_issue got gnt=%b en=%b wen=%h idx=%0d exp 1 1 0 5",
                               fetch_gnt, ram_en, ram_wen, ram_index); end
        step();
        fetch_req = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b1 || fetch_rdata !== {8{32'h1357_9BDF}}) begin
            errors++; $display("FAIL fetch_rdata got v=%b d=%h exp 1 %h", fetch_rvalid, fetch_rdata, {8{32'h1357_9BDF}}); end
        step();
        checks++; if (fetch_rvalid !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL fetch_idle got v=%b en=%b exp 0 0", fetch_rvalid, ram_en); end
    endtask

    task automatic test_refill();
        for (int i = 0; i < 8; i++) exp_line[(6 + i) % 8] = 32'hA0 + 32'(i);
        step();
        refill_start = 1'b1; refill_index = 7'd9; refill_off = 3'd6;
        step();
        refill_start = 1'b0;
        #1;
        checks++; if (refill_busy !== 1'b1 || beat_ready !== 1'b1) begin
            errors++; $display("FAIL fill_enter got busy=%b rdy=%b exp 1 1", refill_busy, beat_ready); end
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1; beat_data = 32'hA0 + 32'(i); beat_last = (i == 7);
            if (i == 2) begin fetch_req = 1'b1; fetch_index = 7'd3; end
            if (i == 3) fetch_index = 7'd9;
            #1;
            if (i == 2) begin
                checks++; if (fetch_gnt !== 1'b1 || ram_index !== 7'd3 || ram_wen !== 32'h0) begin
                    errors++; $display("FAIL fill_fetch_other got gnt=%b idx=%0d wen=%h exp 1 3 0", fetch_gnt, ram_index, ram_wen); end
            end
            if (i == 3) begin
                checks++; if (fetch_gnt !== 1'b0 || ram_en !== 1'b0) begin
                    errors++; $display("FAIL fill_fetch_stale got gnt=%b en=%b exp 0 0", fetch_gnt, ram_en); end
            end
`ifdef ICACHE_CRITICAL_FWD_EN
            if (i == 1) begin
                checks++; if (fwd_valid !== 1'b1 || fwd_data !== 32'hA0) begin
                    errors++; $display("FAIL fwd_first got v=%b d=%h exp 1 000000a0", fwd_valid, fwd_data); end
            end
            if (i == 2) begin
                checks++; if (fwd_valid !== 1'b0 || fwd_data !== 32'hA0) begin
                    errors++; $display("FAIL fwd_one_cycle got v=%b d=%h exp 0 000000a0", fwd_valid, fwd_data); end
            end
`else
            if (i == 1) begin
                checks++; if (fwd_valid !== 1'b0) begin
                    errors++; $display("FAIL fwd_disabled got %b exp 0", fwd_valid); end
            end
`endif
            checks++; if (refill_done !== 1'b0) begin
                errors++; $display("FAIL fill_done_early beat %0d got %b exp 0", i, refill_done); end
            step();
        end
        beat_valid = 1'b0; beat_last = 1'b0;
        #1;
        checks++; if (ram_en !== 1'b1 || ram_wen !== 32'hFFFF_FFFF || ram_index !== 7'd9) begin
            errors++; $display("FAIL write_cmd got en=%b wen=%h idx=%0d exp 1 ffffffff 9", ram_en, ram_wen, ram_index); end
        for (int w = 0; w < 8; w++) begin
            checks++; if (ram_wdata[32*w +: 32] !== exp_line[w]) begin
                errors++; $display("FAIL write_word%0d got %h exp %h", w, ram_wdata[32*w +: 32], exp_line[w]); end
        end
        checks++; if ({fetch_gnt, beat_ready, refill_done, refill_err} !== 4'b0) begin
            errors++; $display("FAIL write_ctl got %b exp 0000", {fetch_gnt, beat_ready, refill_done, refill_err}); end
        step();
        checks++; if (refill_done !== 1'b1 || refill_busy !== 1'b0 || fetch_gnt !== 1'b1 || ram_index !== 7'd9) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b gnt=%b idx=%0d exp 1 0 1 9",
                               refill_done, refill_busy, fetch_gnt, ram_index); end
        fetch_req = 1'b0;
        step();
        checks++; if (refill_done !== 1'b0) begin
            errors++; $display("FAIL done_clear got %b exp 0", refill_done); end
    endtask

    task automatic test_gap_err();
        step();
        refill_start = 1'b1; refill_index = 7'd33; refill_off = 3'd0;
        step();
        refill_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1; beat_data = 32'hB0 + 32'(i); beat_last = (i == 4);
            step();
            beat_valid = 1'b0; beat_last = 1'b0;
            #1;
            if (i == 3) begin
                checks++; if (refill_err !== 1'b0) begin
                    errors++; $display("FAIL err_before got %b exp 0", refill_err); end
            end
            if (i == 4) begin
                checks++; if (refill_err !== 1'b1) begin
                    errors++; $display("FAIL err_early_last got %b exp 1", refill_err); end
            end
            if (i < 7) begin
                checks++; if (ram_en !== 1'b0) begin
                    errors++; $display("FAIL gap_no_write beat %0d got en=%b exp 0", i, ram_en); end
                step(); step();
            end
        end
        checks++; if (ram_wen !== 32'hFFFF_FFFF || ram_index !== 7'd33 || ram_wdata[31:0] !== 32'hB0 || ram_wdata[255:224] !== 32'hB7) begin
            errors++; $display("FAIL gap_write got wen=%h idx=%0d w0=%h w7=%h exp ffffffff 33 b0 b7",
                               ram_wen, ram_index, ram_wdata[31:0], ram_wdata[255:224]); end
        step();
        checks++; if (refill_done !== 1'b1 || refill_err !== 1'b1) begin
            errors++; $display("FAIL gap_done got done=%b err=%b exp 1 1", refill_done, refill_err); end
    endtask

    task automatic test_abort();
        step();
        refill_start = 1'b1; refill_index = 7'd40; refill_off = 3'd1;
        step();
        refill_start = 1'b0;
        #1;
        checks++; if (refill_err !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %b exp 0", refill_err); end
        for (int i = 0; i < 3; i++) begin
            beat_valid = 1'b1; beat_data = 32'hE0 + 32'(i);
            step();
        end
        beat_valid = 1'b0;
        resetn = 1'b0;
        #1;
        checks++; if ({refill_busy, beat_ready, ram_en, refill_done, fwd_valid} !== 5'b0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL abort_outputs got %b fwd=%h exp 00000 0",
                               {refill_busy, beat_ready, ram_en, refill_done, fwd_valid}, fwd_data); end
        step();
        checks++; if (ram_en !== 1'b0 || ram_wen !== 32'h0) begin
            errors++; $display("FAIL abort_no_write got en=%b wen=%h exp 0 0", ram_en, ram_wen); end
        resetn = 1'b1;
        step();
        refill_start = 1'b1; refill_index = 7'd9; refill_off = 3'd0;
        step();
        refill_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1; beat_data = 32'hD0 + 32'(i); beat_last = (i == 7);
            step();
        end
        beat_valid = 1'b0; beat_last = 1'b0;
        #1;
        checks++; if (ram_wen !== 32'hFFFF_FFFF || ram_index !== 7'd9 || ram_wdata[31:0] !== 32'hD0 || ram_wdata[127:96] !== 32'hD3) begin
            errors++; $display("FAIL fresh_write got wen=%h idx=%0d w0=%h w3=%h exp ffffffff 9 d0 d3",
                               ram_wen, ram_index, ram_wdata[31:0], ram_wdata[127:96]); end
        step();
        checks++; if (refill_done !== 1'b1 || refill_err !== 1'b0) begin
            errors++; $display("FAIL fresh_done got done=%b err=%b exp 1 0", refill_done, refill_err); end
    endtask

    task automatic test_back_to_back();
        exp_line[2] = 32'hDEAD_BEEF;
        for (int i = 1; i < 8; i++) exp_line[(2 + i) % 8] = 32'hC0 + 32'(i);
        step();
        fetch_req = 1'b1; fetch_index = 7'd7;
        refill_start = 1'b1; refill_index = 7'd12; refill_off = 3'd2;
        #1;
        checks++; if (fetch_gnt !== 1'b1 || ram_index !== 7'd7 || ram_wen !== 32'h0) begin
            errors++; $display("FAIL both_gnt got gnt=%b idx=%0d wen=%h exp 1 7 0", fetch_gnt, ram_index, ram_wen); end
        step();
        fetch_req = 1'b0; refill_start = 1'b0;
        #1;
        checks++; if (fetch_rvalid !== 1'b1 || refill_busy !== 1'b1) begin
            errors++; $display("FAIL both_accept got rv=%b busy=%b exp 1 1", fetch_rvalid, refill_busy); end
        for (int i = 0; i < 8; i++) begin
            beat_valid = 1'b1; beat_last = (i == 7);
            beat_data = (i == 0) ? 32'hDEAD_BEEF : 32'hC0 + 32'(i);
            refill_start = (i == 3); refill_index = 7'd20; refill_off = 3'd0;
`ifdef ICACHE_CRITICAL_FWD_EN
            if (i == 1) begin
                #1;
                checks++; if (fwd_valid !== 1'b1 || fwd_data !== 32'hDEAD_BEEF) begin
                    errors++; $display("FAIL fwd_crit got v=%b d=%h exp 1 deadbeef", fwd_valid, fwd_data); end
            end
`else
            if (i == 1) begin
                #1;
                checks++; if (fwd_valid !== 1'b0 || fwd_data !== 32'h0) begin
                    errors++; $display("FAIL fwd_off got v=%b d=%h exp 0 0", fwd_valid, fwd_data); end
            end
`endif
            step();
        end
        beat_valid = 1'b0; beat_last = 1'b0; refill_start = 1'b0;
        #1;
        checks++; if (ram_wen !== 32'hFFFF_FFFF || ram_index !== 7'd12) begin
            errors++; $display("FAIL b2b_write got wen=%h idx=%0d exp ffffffff 12", ram_wen, ram_index); end
        for (int w = 0; w < 8; w++) begin
            checks++; if (ram_wdata[32*w +: 32] !== exp_line[w]) begin
                errors++; $display("FAIL b2b_word%0d got %h exp %h", w, ram_wdata[32*w +: 32], exp_line[w]); end
        end
        step();
        checks++; if (refill_done !== 1'b1 || refill_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done got done=%b busy=%b exp 1 0", refill_done, refill_busy); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_refill();
        test_gap_err();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
